// File: rtl/sort_seq.sv
// Sequential bubble sorter for DEPTH sign-magnitude words: LOAD -> SORT -> OUT.
// Optional macro SORT_EARLY_EXIT_EN ends SORT after the first pass with no swaps.
module sort_seq #(
    parameter int N     = 23,
    parameter int M     = 8,
    parameter int L     = N + M + 1,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [L-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [L-1:0] out_data,
    output logic         busy
);

    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_SLOT = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_CMP  = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [IW-1:0] wr_idx_r, wr_idx_s;
    logic [IW-1:0] rd_idx_r, rd_idx_s;
    logic [IW-1:0] pass_r, pass_s;
    logic [IW-1:0] cmp_r, cmp_s;
    logic [IW-1:0] cmp_nx_s;
    logic [L-1:0]  mem_r [DEPTH];
    logic [L-1:0]  lo_s, hi_s;
    logic          swap_s;
    logic          sort_done_s;
`ifdef SORT_EARLY_EXIT_EN
    logic          swapped_r, swapped_s;
`endif

    // Ordering on sign-magnitude words; +0 ranks above -0, identical words tie.
    function automatic logic word_gt(input logic [L-1:0] a, input logic [L-1:0] b);
        logic res;
        if (a == b) begin
            res = 1'b0;
        end else if (a[L-1] != b[L-1]) begin
            res = ~a[L-1];
        end else if (a[L-1] == 1'b0) begin
            res = (a[L-2:0] > b[L-2:0]);
        end else begin
            res = (a[L-2:0] < b[L-2:0]);
        end
        return res;
    endfunction

    // Next-state, index updates and compare/swap decision.
    always_comb begin
        state_s     = state_r;
        wr_idx_s    = wr_idx_r;
        rd_idx_s    = rd_idx_r;
        pass_s      = pass_r;
        cmp_s       = cmp_r;
        cmp_nx_s    = cmp_r + IW'(1);
        lo_s        = mem_r[cmp_r];
        hi_s        = mem_r[cmp_nx_s];
        swap_s      = (state_r == SORT) && word_gt(lo_s, hi_s);
        sort_done_s = (pass_r == LAST_CMP);
`ifdef SORT_EARLY_EXIT_EN
        swapped_s   = 1'b0;
        if (state_r == SORT && cmp_r != LAST_CMP) begin
            swapped_s = swapped_r | swap_s;
        end else begin
            swapped_s = 1'b0;
        end
        // A full pass without a single swap means the array is already ordered.
        if (!(swapped_r | swap_s)) begin
            sort_done_s = 1'b1;
        end else begin
            sort_done_s = (pass_r == LAST_CMP);
        end
`endif
        case (state_r)
            LOAD: begin
                if (in_valid) begin
                    if (wr_idx_r == LAST_SLOT) begin
                        wr_idx_s = {IW{1'b0}};
                        state_s  = SORT;
                    end else begin
                        wr_idx_s = wr_idx_r + IW'(1);
                    end
                end else begin
                    wr_idx_s = wr_idx_r;
                end
            end
            SORT: begin
                if (cmp_r == LAST_CMP) begin
                    cmp_s = {IW{1'b0}};
                    if (sort_done_s) begin
                        pass_s   = {IW{1'b0}};
                        rd_idx_s = {IW{1'b0}};
                        state_s  = OUT;
                    end else begin
                        pass_s = pass_r + IW'(1);
                    end
                end else begin
                    cmp_s = cmp_nx_s;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (rd_idx_r == LAST_SLOT) begin
                        rd_idx_s = {IW{1'b0}};
                        wr_idx_s = {IW{1'b0}};
                        state_s  = LOAD;
                    end else begin
                        rd_idx_s = rd_idx_r + IW'(1);
                    end
                end else begin
                    rd_idx_s = rd_idx_r;
                end
            end
            default: begin
                state_s = LOAD;
            end
        endcase
    end

    // State and index registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= LOAD;
            wr_idx_r <= {IW{1'b0}};
            rd_idx_r <= {IW{1'b0}};
            pass_r   <= {IW{1'b0}};
            cmp_r    <= {IW{1'b0}};
        end else begin
            state_r  <= state_s;
            wr_idx_r <= wr_idx_s;
            rd_idx_r <= rd_idx_s;
            pass_r   <= pass_s;
            cmp_r    <= cmp_s;
        end
    end

`ifdef SORT_EARLY_EXIT_EN
    // Per-pass swap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            swapped_r <= 1'b0;
        end else begin
            swapped_r <= swapped_s;
        end
    end
`endif

    // Word storage: not reset, written by loads and by swaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= mem_r[0];
        end else if (state_r == LOAD && in_valid) begin
            mem_r[wr_idx_r] <= in_data;
        end else if (swap_s) begin
            mem_r[cmp_r]    <= hi_s;
            mem_r[cmp_nx_s] <= lo_s;
        end else begin
            mem_r[0] <= mem_r[0];
        end
    end

    // in_ready is held low for as long as rst is asserted.
    assign in_ready  = (state_r == LOAD) && !rst;
    assign out_valid = (state_r == OUT);
    assign busy      = (state_r == SORT) || (state_r == OUT);
    assign out_data  = (state_r == OUT) ? mem_r[rd_idx_r] : {L{1'b0}};

endmodule

// File: tb/tb_sort_seq.sv
// Scoreboard bench for sort_seq: stimulus pushes model results, a monitor pops on handshakes.
module tb_sort_seq;
    localparam int N = 23;
    localparam int M = 8;
    localparam int L = 32;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [L-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [L-1:0] out_data;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [L-1:0] exp_q[$];
    int ready_mode = 0;
    int rcnt = 0;
    int batch_hs = 0;
    bit ir_check = 1'b0;
    bit hold_pend = 1'b0;
    logic [L-1:0] hold_val;

    sort_seq #(.N(N), .M(M), .L(L), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ordering key: -0 -> -1, +0 -> 0, positive grows with magnitude, negative shrinks.
    function automatic longint word_key(input logic [L-1:0] w);
        longint mag;
        mag = longint'(w[L-2:0]);
        return w[L-1] ? (-(2 * mag) - 1) : (2 * mag);
    endfunction

    task automatic push_model(input logic [L-1:0] w[DEPTH]);
        logic [L-1:0] a[DEPTH];
        logic [L-1:0] t;
        a = w;
        for (int i = 1; i < DEPTH; i++) begin
            for (int j = i; j > 0; j--) begin
                if (word_key(a[j-1]) > word_key(a[j])) begin
                    t = a[j-1]; a[j-1] = a[j]; a[j] = t;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(a[i]);
    endtask

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    always @(posedge clk) begin
        #1;
        rcnt = rcnt + 1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares every output handshake against the scoreboard queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ir_check) begin
                check("in_ready_after_last_hs", {63'd0, in_ready}, 64'd1);
                check("busy_after_last_hs", {63'd0, busy}, 64'd0);
                ir_check = 1'b0;
            end
            if (hold_pend && out_valid) check("stall_hold", {32'd0, out_data}, {32'd0, hold_val});
            hold_pend = 1'b0;
            if (busy) check("in_ready_low_when_busy", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected no output", out_data);
                end else begin
                    check("out_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
                    batch_hs++;
                    if (batch_hs == DEPTH) begin
                        batch_hs = 0;
                        ir_check = 1'b1;
                    end
                end
            end else if (out_valid) begin
                hold_pend = 1'b1;
                hold_val  = out_data;
            end
        end else begin
            hold_pend = 1'b0;
            ir_check  = 1'b0;
            batch_hs  = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_in_ready: in_ready=%b expected 1 within 300 cycles", in_ready);
        end
    endtask

    task automatic load(input logic [L-1:0] w[DEPTH], input bit push);
        wait_ready();
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (push) push_model(w);
    endtask

    // Counts busy cycles before out_valid while driving junk that must be ignored.
    task automatic measure_sort(output int cnt);
        bit done = 1'b0;
        int n = 0;
        cnt = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) done = 1'b1;
            else begin
                if (busy) cnt++;
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
        end
        in_valid = 1'b0;
        if (!done) cnt = -1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic run_batch(input string name, input logic [L-1:0] w[DEPTH], input int mode, input int exact_len);
        int cnt;
        ready_mode = mode;
        load(w, 1'b1);
        measure_sort(cnt);
`ifdef SORT_EARLY_EXIT_EN
        if (exact_len > 0) check({name, "_sort_len"}, 64'(cnt), 64'(exact_len));
        else check({name, "_sort_len_range"}, {63'd0, (cnt >= 7 && cnt <= 49 && cnt % 7 == 0)}, 64'd1);
`else
        check({name, "_sort_len"}, 64'(cnt), 64'd49);
`endif
        drain();
    endtask

    initial begin
        logic [L-1:0] w[DEPTH];
        int cnt;
        logic [L-1:0] pool[4];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_data", {32'd0, out_data}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        w = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
              32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        run_batch("reverse", w, 0, 49);

        w = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        run_batch("presorted", w, 0, 7);

        w = '{32'hC0000000, 32'h3F800000, 32'hBF000000, 32'h00000000,
              32'h80000000, 32'h40400000, 32'hC0000000, 32'h3E800000};
        run_batch("mixed_backpressure", w, 1, 0);

        // Reset on the 20th SORT cycle abandons the batch.
        ready_mode = 0;
        for (int i = 0; i < DEPTH; i++) w[i] = $urandom;
        load(w, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midsort_rst_busy", {63'd0, busy}, 64'd0);
        check("midsort_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midsort_rst_in_ready", {63'd0, in_ready}, 64'd1);

        for (int b = 0; b < 10; b++) begin
            pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000};
            for (int i = 0; i < DEPTH; i++) begin
                case ($urandom_range(0, 3))
                    0: w[i] = pool[$urandom_range(0, 3)];
                    1: w[i] = (i > 0) ? w[i-1] : $urandom;
                    default: w[i] = $urandom;
                endcase
            end
            run_batch("random", w, $urandom_range(0, 2), 0);
        end

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
